// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the sequential MIPS-subset core: walks each
// instruction through its fetch/decode/execute/memory/writeback states and counts retirements.
`timescale 1ns/1ps
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        branch,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // {supported, alu operation} for an R-type funct field
  function automatic logic [4:0] funct_decode(input logic [5:0] f);
    logic [4:0] r;
    case (f)
      6'h20:   r = {1'b1, ALU_ADD};
      6'h22:   r = {1'b1, ALU_SUB};
      6'h24:   r = {1'b1, ALU_AND};
      6'h25:   r = {1'b1, ALU_OR};
      6'h26:   r = {1'b1, ALU_XOR};
      6'h27:   r = {1'b1, ALU_NOR};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire_s;
  logic        pc_write_s, ir_write_s, reg_write_s, mem_write_s, branch_s, illegal_s;
  logic [4:0]  funct_dec_s;

  assign funct_dec_s = funct_decode(funct);

  // Next-state, retirement and control decode
  always_comb begin
    state_d     = state_q;
    retire_s    = 1'b0;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    illegal_s   = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        pc_write_s = mem_ready;
        ir_write_s = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) state_d = S_MEMRD;
        else                 state_d = S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_dec_s[3:0];
        if (funct_dec_s[4]) state_d = S_RWB;
        else                state_d = S_ILLEGAL;
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        branch_s  = 1'b1;
        pc_src    = 2'b01;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src     = 2'b10;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_s = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (retire_s) instr_count_d = instr_count_q + 32'd1;
    else          instr_count_d = instr_count_q;
  end

  // State and retirement counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Architectural write strobes are suppressed for as long as reset is held
  assign pc_write    = pc_write_s  & ~reset;
  assign ir_write    = ir_write_s  & ~reset;
  assign reg_write   = reg_write_s & ~reset;
  assign mem_write   = mem_write_s & ~reset;
  assign branch      = branch_s    & ~reset;
  assign illegal     = illegal_s   & ~reset;
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction reference model pushes one expected
// record per cycle, and a negedge monitor pops and compares it against the DUT.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        pc_write, branch, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_ctrl, state;
  logic [31:0] instr_count;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  // ALU code for a funct; 4'hF marks an unsupported funct
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h26:   return 4'b0011;
      6'h27:   return 4'b0100;
      default: return 4'hF;
    endcase
  endfunction

  // Expected control word for one cycle spent in state st
  function automatic logic [18:0] exp_ctrl(input int st, input bit mr, input logic [5:0] fn);
    logic pw, br, irw, io, mrd, mwr, rw, rd, m2r, sa, il;
    logic [1:0] ps, sb;
    logic [3:0] ac;
    {pw, br, irw, io, mrd, mwr, rw, rd, m2r, sa, il} = 11'd0;
    ps = 2'd0; sb = 2'd0; ac = 4'b0010;
    case (st)
      0:  begin mrd = 1'b1; sb = 2'b01; pw = mr; irw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mrd = 1'b1; io = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; io = 1'b1; end
      6:  begin sa = 1'b1; ac = (r_alu(fn) == 4'hF) ? 4'b0010 : r_alu(fn); end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin sa = 1'b1; ac = 4'b0110; br = 1'b1; ps = 2'b01; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: rw = 1'b1;
      11: begin pw = 1'b1; ps = 2'b10; end
      12: il = 1'b1;
      default: ;
    endcase
    return {pw, br, ps, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, ac, il};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One model cycle: drive mem_ready, record the expectation, advance to just after the edge
  task automatic cyc(input int st, input bit mr, input bit retire);
    exp_t e;
    mem_ready = mr;
    e.st   = st[3:0];
    e.ctrl = exp_ctrl(st, mr, funct);
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    if (retire) model_cnt = model_cnt + 32'd1;
    @(posedge clk); #1;
  endtask

  // Full instruction: fw stalls in FETCH, mw stalls in the memory-access state
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fw; i++) cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(1, rb(), 1'b0);
    case (op)
      6'h23: begin
        cyc(2, rb(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(3, 1'b0, 1'b0);
        cyc(3, 1'b1, 1'b0);
        cyc(4, rb(), 1'b1);
      end
      6'h2B: begin
        cyc(2, rb(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(5, 1'b0, 1'b0);
        cyc(5, 1'b1, 1'b1);
      end
      6'h00: begin
        cyc(6, rb(), 1'b0);
        if (r_alu(fn) != 4'hF) cyc(7, rb(), 1'b1);
        else                   cyc(12, rb(), 1'b0);
      end
      6'h04: cyc(8, rb(), 1'b1);
      6'h08: begin cyc(9, rb(), 1'b0); cyc(10, rb(), 1'b1); end
      6'h02: cyc(11, rb(), 1'b1);
      default: cyc(12, rb(), 1'b0);
    endcase
  endtask

  // Monitor: every non-reset cycle must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [18:0] act;
    if (mon_en && !reset) begin
      act = {pc_write, branch, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got state %0d with no expectation queued", state);
      end else begin
        e = exp_q.pop_front();
        if (state !== e.st || act !== e.ctrl || instr_count !== e.cnt) begin
          errors++;
          $display("FAIL cycle: got st=%0d ctrl=%b cnt=%h expected st=%0d ctrl=%b cnt=%h",
                   state, act, instr_count, e.st, e.ctrl, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    int r;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_pc_write", {31'd0, pc_write}, 32'd0);
    chk("reset_ir_write", {31'd0, ir_write}, 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;

    run_instr(6'h00, 6'h20, 0, 0);   // add $3,$3,$2
    run_instr(6'h23, 6'h04, 0, 2);   // lw with two MEMRD stalls
    run_instr(6'h04, 6'h00, 0, 0);   // beq
    run_instr(6'h04, 6'h3C, 1, 0);   // beq
    run_instr(6'h02, 6'h00, 0, 0);   // j
    run_instr(6'h3F, 6'h00, 0, 0);   // unsupported opcode
    run_instr(6'h00, 6'h21, 0, 0);   // unsupported funct
    run_instr(6'h2B, 6'h00, 2, 1);   // sw with stalls

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      fn = 6'($urandom_range(0, 63));
      case (r)
        0, 9: op = 6'h23;
        1:    op = 6'h2B;
        2, 3: begin op = 6'h00; fn = 6'h20 + 6'($urandom_range(0, 7)); end
        4:    op = 6'h00;
        5:    op = 6'h04;
        6:    op = 6'h08;
        7:    op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
                 op == 6'h23 || op == 6'h2B) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while lw is stalled in MEMRD
    opcode = 6'h23; funct = 6'h00;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b0);
    cyc(2, 1'b1, 1'b0);
    cyc(3, 1'b0, 1'b0);
    chk("stall_in_memrd", {28'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("abort_state", {28'd0, state}, 32'd0);
    chk("abort_count", instr_count, 32'd0);
    chk("abort_reg_write", {31'd0, reg_write}, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("rst_hold_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_hold_ir_write", {31'd0, ir_write}, 32'd0);
    chk("rst_hold_mem_read", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    chk("rst_hold_reg_write", {31'd0, reg_write}, 32'd0);
    reset = 1'b0;
    model_cnt = 32'd0;
    run_instr(6'h08, 6'h00, 0, 0);
    chk("count_after_abort", instr_count, 32'd1);

    // Counter wrap on a retiring addi
    force dut.instr_count_q = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    run_instr(6'h08, 6'h00, 0, 0);
    chk("count_wrap", instr_count, 32'd0);

    run_instr(6'h00, 6'h27, 1, 0);
    chk("queue_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the sequential MIPS-subset core. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the enables and selects for the PC register, instruction register, register file, ALU and unified memory. It also produces the `branch` strobe that the PC block ANDs with the ALU `zero` flag. Memory accesses use a ready handshake, and the block keeps a retired-instruction counter.

## Interface
- Parameters: none; all encodings below are fixed.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; one clock domain.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: conditional PC load; the PC block loads when `branch & zero`.
- `pc_src` out 2: PC next-value select. 00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump target {PC[31:28], IR[25:0], 2'b00}.
- `ir_write` out 1: instruction register load.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback data select. 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = regA.
- `alu_src_b` out 2: ALU B select. 00 = regB, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_ctrl` out 4: ALU operation. AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110.
- `illegal` out 1: one-cycle pulse for an unsupported opcode/funct.
- `state` out 4: current state, for debug.
- `instr_count` out 32: count of retired legal instructions.

## Operation
- States:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12
- Outputs not listed for a state are 0; `alu_ctrl` defaults to ADD.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=00.
  - `pc_write` and `ir_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11 to precompute the branch target.
  - Next state by opcode: 0x23/0x2B → MEMADR, 0x00 → EXEC, 0x04 → BRANCH, 0x08 → ADDIEX, 0x02 → JUMP, any other → ILLEGAL.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEMRD if opcode is 0x23, else MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
- EXEC:
  - `alu_src_a`=1, `alu_src_b`=00; `alu_ctrl` from `funct`: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - Goes to RWB; any other `funct` goes to ILLEGAL instead.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl`=SUB, `branch`=1, `pc_src`=01. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0. Goes to FETCH.
- JUMP: `pc_write`=1, `pc_src`=10. Goes to FETCH.
- ILLEGAL:
  - `illegal`=1 for one cycle, no architectural write, then FETCH.
  - The PC was already advanced in FETCH, so execution resumes at the next instruction.
- `instr_count`:
  - +1 on the final cycle of every legal instruction: MEMWB, RWB, ADDIWB, BRANCH, JUMP, and the MEMWR cycle with `mem_ready`=1.
  - Wraps from 0xFFFFFFFF to 0. Never increments in ILLEGAL.
- `mem_read` and `mem_write` are never both 1.

## Timing
- State register and `instr_count` update on the `clk` rising edge.
- All other outputs are combinational from `state`, `opcode`, `funct` and `mem_ready`.
- Reset:
  - `reset`=1 immediately forces `state`=FETCH and `instr_count`=0.
  - While `reset` is high, `pc_write`, `ir_write`, `reg_write`, `mem_write`, `branch` and `illegal` are forced to 0. `mem_read`=1 is permitted.
  - Reset mid-instruction aborts it with no further write. The first fetch starts on the first edge after deassertion.
- Latency in cycles with `mem_ready` held at 1:
  - lw 5; sw, R-type, addi 4; beq, j 3; illegal 3.
  - Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- `opcode`/`funct` must stay stable from DECODE until the return to FETCH; IR is written only in FETCH.

## Test plan
- Reset mid-MEMRD, `mem_ready`=0:
  - Required: `state`=0 immediately; `instr_count`=0; no `reg_write` pulse.
  - After release, FETCH issues `mem_read`=1 with `iord`=0.
- Instruction 0x00621820 (add), `mem_ready`=1:
  - State sequence 0,1,6,7,0.
  - `alu_ctrl`=0010 in EXEC; `reg_write`=`reg_dst`=1 in RWB; `instr_count` +1.
- Instruction 0x8C020004 (lw) with `mem_ready` low for 2 cycles in MEMRD:
  - States 0,1,2,3,3,3,4,0; 7 cycles total.
  - `mem_to_reg`=1 in MEMWB.
- beq with `zero`=1 and with `zero`=0:
  - `branch`=1 and `pc_src`=01 in state 8 in both cases; 3 cycles; `instr_count` +1 each time.
- Instruction 0x08000000 (j):
  - `pc_write`=1, `pc_src`=10 in JUMP.
  - Opcode 0x3F gives an `illegal` pulse in state 12 and `instr_count` unchanged.
- Preload `instr_count`=0xFFFFFFFF via 2^32−1 retirements (forced), then one addi: `instr_count` wraps to 0.
